// File: rtl/prio_enc_hist.sv
// Registered priority encoder that logs each new valid code into a shift history shown on 7-seg digits.
// Optional input debouncer is enabled by defining PRIO_DEBOUNCE_EN.
module prio_enc_hist #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int DB_CYC = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           x,
  input  logic                       en,
  input  logic                       clr,
  output logic [$clog2(WIDTH)-1:0]   y,
  output logic                       l,
  output logic                       push,
  output logic [3:0]                 count,
  output logic [7*DEPTH-1:0]         hex
);

  localparam int IDX_W = $clog2(WIDTH);

  if (WIDTH < 2 || WIDTH > 16 || DEPTH < 1 || DEPTH > 8 || DB_CYC < 2 || DB_CYC > 255)
  begin : g_param_check
    $error("prio_enc_hist: parameter out of range");
  end

  logic [WIDTH-1:0] x_src;

`ifdef PRIO_DEBOUNCE_EN
  // stab_q counts consecutive cycles x has equalled samp_q, including the latest sample.
  logic [WIDTH-1:0] samp_q, samp_d;
  logic [WIDTH-1:0] db_q, db_d;
  logic [7:0]       stab_q, stab_d;

  always_comb begin
    samp_d = x;
    db_d   = db_q;
    if (x == samp_q) begin
      stab_d = (stab_q == 8'hFF) ? stab_q : stab_q + 8'd1;
    end else begin
      stab_d = 8'd1;
    end
    if (stab_d >= 8'(DB_CYC)) begin
      db_d = x;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_q <= '0;
      db_q   <= '0;
      stab_q <= '0;
    end else begin
      samp_q <= samp_d;
      db_q   <= db_d;
      stab_q <= stab_d;
    end
  end

  assign x_src = db_q;
`else
  assign x_src = x;
`endif

  logic [IDX_W-1:0]      y_q, y_d;
  logic                  l_q, l_d;
  logic                  push_q, push_d;
  logic [3:0]            count_q, count_d;
  logic [DEPTH-1:0][3:0] hist_q, hist_d;
  logic                  evt;

  // Ascending scan: the last set bit seen is the highest-priority one.
  always_comb begin
    y_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (x_src[i]) begin
        y_d = IDX_W'(i);
      end
    end
    if (!en) begin
      y_d = '0;
    end
    l_d = en && (|x_src);
  end

  assign evt = l_d && (!l_q || (y_d != y_q));

  always_comb begin
    hist_d  = hist_q;
    count_d = count_q;
    push_d  = 1'b0;
    if (clr) begin
      hist_d  = '0;
      count_d = 4'd0;
    end else if (evt) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        hist_d[k] = hist_q[k-1];
      end
      hist_d[0] = 4'(y_d);
      count_d   = (count_q == 4'(DEPTH)) ? count_q : count_q + 4'd1;
      push_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q     <= '0;
      l_q     <= 1'b0;
      push_q  <= 1'b0;
      count_q <= 4'd0;
      hist_q  <= '0;
    end else begin
      y_q     <= y_d;
      l_q     <= l_d;
      push_q  <= push_d;
      count_q <= count_d;
      hist_q  <= hist_d;
    end
  end

  assign y     = y_q;
  assign l     = l_q;
  assign push  = push_q;
  assign count = count_q;

  function automatic logic [6:0] seg7(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Entries at or beyond count are stale/empty and shown blank.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_digit
    assign hex[7*gi +: 7] = (4'(gi) < count_q) ? seg7(hist_q[gi]) : 7'h7F;
  end

endmodule
